boot_overlay_ctrl: RTL and testbench

Arbiter and sequencer for the boot ROM overlay region. It accepts read requests from the CPU and the DMA engine and picks one winner per transaction. Each read is steered to the synchronous boot ROM or to the cartridge bus, based on the overlay window, the console mode and the write-once boot lock register (FF50). It sits between the CPU/DMA address decode and the boot ROM / cartridge interface, and owns the `use_cart` state.

---
 rtl/boot_overlay_pkg.sv | 32 +++
 rtl/boot_overlay_ctrl_if.sv | 37 +++
 rtl/boot_lock_reg.sv | 26 ++
 rtl/boot_overlay_ctrl.sv | 143 ++++++++++++++
 tb/tb_boot_overlay_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_overlay_pkg.sv
// Shared types and constants for the boot ROM overlay arbiter/sequencer.
package boot_overlay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        ROM_RET,
        CART_WAIT,
        CART_RET
    } ovl_state_t;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DMA = 1'b1
    } ovl_src_t;

    localparam logic [15:0] DMG_WIN_HI   = 16'h00FF;
    localparam logic [15:0] CGB_WIN2_LO  = 16'h0200;
    localparam logic [15:0] CGB_WIN2_HI  = 16'h08FF;
    localparam logic [7:0]  TIMEOUT_DATA = 8'hFF;

    // The overlay only exists while the boot lock has not handed the map to the cartridge.
    function automatic logic is_overlay_hit(input logic [15:0] addr,
                                            input logic        cgb,
                                            input logic        use_cart);
        logic in_win;
        in_win = (addr <= DMG_WIN_HI) ||
                 (cgb && (addr >= CGB_WIN2_LO) && (addr <= CGB_WIN2_HI));
        return !use_cart && in_win;
    endfunction

endpackage

// File: rtl/boot_overlay_ctrl_if.sv
// Requester (CPU/DMA) and memory-side (boot ROM / cartridge) signals of the overlay controller.
interface boot_overlay_ctrl_if;
    import boot_overlay_pkg::*;

    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;

    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;

    logic [11:0] rom_addr;
    logic [7:0]  rom_rdata;

    logic        cart_req;
    logic [15:0] cart_addr;
    logic        cart_ack;
    logic [7:0]  cart_rdata;

    modport slave (
        input  cpu_req, cpu_addr, dma_req, dma_addr, rom_rdata, cart_ack, cart_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
               rom_addr, cart_req, cart_addr
    );

    modport master (
        output cpu_req, cpu_addr, dma_req, dma_addr, rom_rdata, cart_ack, cart_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
               rom_addr, cart_req, cart_addr
    );

endinterface

// File: rtl/boot_lock_reg.sv
// Write-once FF50 boot lock: loads until bit 0 is set, then frozen until reset.
module boot_lock_reg
    import boot_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lock_write,
    input  logic [7:0] lock_wdata,
    output logic [7:0] lock_rdata,
    output logic       use_cart
);

    logic [7:0] lock_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_reg <= 8'h00;
        end else if (lock_write && !lock_reg[0]) begin
            lock_reg <= lock_wdata;
        end
    end

    assign lock_rdata = lock_reg;
    assign use_cart   = lock_reg[0];

endmodule

// File: rtl/boot_overlay_ctrl.sv
// Arbitrates CPU/DMA reads and sequences each one to the boot ROM or the cartridge bus.
module boot_overlay_ctrl
    import boot_overlay_pkg::*;
#(
    parameter int CART_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cgb_hard,
    input  logic               lock_write,
    input  logic [7:0]         lock_wdata,
    output logic [7:0]         lock_rdata,
    output logic               use_cart,
    boot_overlay_ctrl_if.slave bus
);

    localparam logic [9:0] TMO_LAST = 10'(CART_TIMEOUT - 1);

    ovl_state_t  state, state_nxt;
    ovl_src_t    req_src, src_p1;
    logic [15:0] req_addr;
    logic        grant, hit, cart_done, ret_fire;
    logic        cpu_gnt, dma_gnt;
    logic [9:0]  tmo_cnt;
    logic [7:0]  ret_data;

    logic        cpu_rvalid, dma_rvalid, cart_req;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic [11:0] rom_addr;
    logic [15:0] cart_addr;

    boot_lock_reg u_lock (
        .clk        (clk),
        .reset      (reset),
        .lock_write (lock_write),
        .lock_wdata (lock_wdata),
        .lock_rdata (lock_rdata),
        .use_cart   (use_cart)
    );

    // use_cart here is the pre-write value, so a lock write in the grant cycle
    // only affects later grants.
    assign hit = is_overlay_hit(req_addr, cgb_hard, use_cart);

    always_comb begin
        state_nxt = state;
        req_addr  = bus.cpu_addr;
        req_src   = SRC_CPU;
        grant     = 1'b0;
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        cart_done = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (bus.dma_req) begin
                        dma_gnt  = 1'b1;
                        grant    = 1'b1;
                        req_addr = bus.dma_addr;
                        req_src  = SRC_DMA;
                    end else if (bus.cpu_req) begin
                        cpu_gnt = 1'b1;
                        grant   = 1'b1;
                    end
                end
                if (grant) begin
                    state_nxt = hit ? ROM_RD : CART_WAIT;
                end
            end
            ROM_RD:  state_nxt = ROM_RET;
            ROM_RET: state_nxt = IDLE;
            CART_WAIT: begin
                // An ack in the timeout cycle still wins; its data is taken below.
                if (bus.cart_ack || (tmo_cnt == TMO_LAST)) begin
                    cart_done = 1'b1;
                    state_nxt = CART_RET;
                end
            end
            CART_RET: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign ret_fire = (state == ROM_RD) || cart_done;
    assign ret_data = (state == ROM_RD) ? bus.rom_rdata :
                      (bus.cart_ack ? bus.cart_rdata : TIMEOUT_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_p1     <= SRC_CPU;
            tmo_cnt    <= '0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
            dma_rdata  <= 8'h00;
            rom_addr   <= 12'h000;
            cart_addr  <= 16'h0000;
            cart_req   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            if (grant) begin
                src_p1  <= req_src;
                tmo_cnt <= '0;
                if (hit) begin
                    rom_addr <= req_addr[11:0];
                end else begin
                    cart_addr <= req_addr;
                    cart_req  <= 1'b1;
                end
            end
            if (state == CART_WAIT) begin
                tmo_cnt <= tmo_cnt + 10'd1;
            end
            if (cart_done) begin
                cart_req <= 1'b0;
            end
            // Return stage: only the tagged source sees rvalid and new data.
            if (ret_fire) begin
                if (src_p1 == SRC_DMA) begin
                    dma_rvalid <= 1'b1;
                    dma_rdata  <= ret_data;
                end else begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= ret_data;
                end
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.dma_rdata  = dma_rdata;
    assign bus.rom_addr   = rom_addr;
    assign bus.cart_req   = cart_req;
    assign bus.cart_addr  = cart_addr;

endmodule

// File: tb/tb_boot_overlay_ctrl.sv
// Directed bench for boot_overlay_ctrl: scoreboard of read returns plus cycle-exact timing checks.
module tb_boot_overlay_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cgb_hard;
    logic       lock_write;
    logic [7:0] lock_wdata;
    logic [7:0] lock_rdata;
    logic       use_cart;

    boot_overlay_ctrl_if bus();

    boot_overlay_ctrl #(.CART_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cgb_hard   (cgb_hard),
        .lock_write (lock_write),
        .lock_wdata (lock_wdata),
        .lock_rdata (lock_rdata),
        .use_cart   (use_cart),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: ROM[a] = a[7:0] ^ 8'h0A  (0x034 -> 3E, 0x010 -> 1A, 0x020 -> 2A, 0x050 -> 5A, 0x200 -> 0A)
    assign bus.rom_rdata = bus.rom_addr[7:0] ^ 8'h0A;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [7:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops an expected return for every rvalid pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_rvalid || bus.dma_rvalid) begin
                check("rvalid_exclusive", {31'd0, bus.cpu_rvalid & bus.dma_rvalid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, bus.dma_rvalid, bus.cpu_rvalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ret_src", {31'd0, bus.dma_rvalid}, {31'd0, e.src});
                    check("ret_data", {24'd0, e.src ? bus.dma_rdata : bus.cpu_rdata}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cgb_hard = 1'b0; lock_write = 1'b0; lock_wdata = 8'h00;
        bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0000;
        bus.dma_req = 1'b0; bus.dma_addr = 16'h0000;
        bus.cart_ack = 1'b0; bus.cart_rdata = 8'h00;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        @(negedge clk);
        check("rst_cart_req", {31'd0, bus.cart_req}, 32'd0);
        check("rst_rom_addr", {20'd0, bus.rom_addr}, 32'h000);
        check("rst_cart_addr", {16'd0, bus.cart_addr}, 32'h0000);
        check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'h00);
        check("rst_lock", {24'd0, lock_rdata}, 32'h00);
        check("rst_use_cart", {31'd0, use_cart}, 32'd0);

        // DMG ROM read of 0x0034
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0034;
        @(negedge clk);
        check("rom_cpu_gnt_N", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h3E);
        cyc(); bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rom_addr_N1", {20'd0, bus.rom_addr}, 32'h034);
        check("rom_rvalid_N1", {31'd0, bus.cpu_rvalid}, 32'd0);
        cyc();
        @(negedge clk);
        check("rom_rvalid_N2", {31'd0, bus.cpu_rvalid}, 32'd1);
        cyc();

        // 0x0200 in DMG mode goes to the cartridge; ack in N+1
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0200;
        @(negedge clk);
        check("cart_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'hC7);
        cyc(); bus.cpu_req = 1'b0; bus.cart_ack = 1'b1; bus.cart_rdata = 8'hC7;
        @(negedge clk);
        check("cart_req_N1", {31'd0, bus.cart_req}, 32'd1);
        check("cart_addr_N1", {16'd0, bus.cart_addr}, 32'h0200);
        cyc(); bus.cart_ack = 1'b0;
        @(negedge clk);
        check("cart_req_drop", {31'd0, bus.cart_req}, 32'd0);
        check("cart_rvalid_N2", {31'd0, bus.cpu_rvalid}, 32'd1);
        cyc();

        // Same address in CGB mode hits the second overlay window
        cgb_hard = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0200;
        @(negedge clk);
        check("cgb_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h0A);
        cyc(); bus.cpu_req = 1'b0;
        @(negedge clk);
        check("cgb_rom_addr", {20'd0, bus.rom_addr}, 32'h200);
        check("cgb_no_cart", {31'd0, bus.cart_req}, 32'd0);
        cyc(); cyc();
        cgb_hard = 1'b0;

        // Contention: DMA wins, CPU served in the first IDLE after dma_rvalid
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1'b1; bus.dma_addr = 16'h0020;
        @(negedge clk);
        check("cont_dma_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        check("cont_cpu_nogntN", {31'd0, bus.cpu_gnt}, 32'd0);
        push(1'b1, 8'h2A);
        cyc(); bus.dma_req = 1'b0;
        @(negedge clk);
        check("cont_cpu_nogntN1", {31'd0, bus.cpu_gnt}, 32'd0);
        cyc();
        @(negedge clk);
        check("cont_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        check("cont_cpu_nogntN2", {31'd0, bus.cpu_gnt}, 32'd0);
        cyc();
        @(negedge clk);
        check("cont_cpu_gntN3", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h1A);
        cyc(); bus.cpu_req = 1'b0;
        cyc();
        @(negedge clk);
        check("cont_dma_rdata_hold", {24'd0, bus.dma_rdata}, 32'h2A);
        cyc();

        // Lock write in the grant cycle: this read still comes from the ROM
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0050;
        lock_write = 1'b1; lock_wdata = 8'h01;
        @(negedge clk);
        check("lock_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h5A);
        cyc(); bus.cpu_req = 1'b0; lock_write = 1'b0;
        @(negedge clk);
        check("lock_rd_rom", {31'd0, bus.cart_req}, 32'd0);
        check("lock_rom_addr", {20'd0, bus.rom_addr}, 32'h050);
        check("lock_use_cart", {31'd0, use_cart}, 32'd1);
        cyc(); cyc();
        bus.cpu_req = 1'b1;
        @(negedge clk);
        check("lock2_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h96);
        cyc(); bus.cpu_req = 1'b0; bus.cart_ack = 1'b1; bus.cart_rdata = 8'h96;
        @(negedge clk);
        check("lock2_cart_req", {31'd0, bus.cart_req}, 32'd1);
        check("lock2_cart_addr", {16'd0, bus.cart_addr}, 32'h0050);
        cyc(); bus.cart_ack = 1'b0;
        cyc();
        lock_write = 1'b1; lock_wdata = 8'h00;
        cyc(); lock_write = 1'b0;
        @(negedge clk);
        check("lock_write_once", {24'd0, lock_rdata}, 32'h01);

        // Cart timeout with no ack: rvalid with FF at N+5
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h1234;
        @(negedge clk);
        check("tmo_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'hFF);
        cyc(); bus.cpu_req = 1'b0;
        @(negedge clk);
        check("tmo_cart_req", {31'd0, bus.cart_req}, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            @(negedge clk);
            check("tmo_early_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
        end
        cyc();
        @(negedge clk);
        check("tmo_rvalid_N5", {31'd0, bus.cpu_rvalid}, 32'd1);
        check("tmo_cart_req_low", {31'd0, bus.cart_req}, 32'd0);
        cyc();
        @(negedge clk);
        check("tmo_cart_req_after", {31'd0, bus.cart_req}, 32'd0);

        // DMA read with the ack landing in the timeout cycle: ack data wins
        cyc();
        bus.dma_req = 1'b1; bus.dma_addr = 16'h4321;
        @(negedge clk);
        check("tmoack_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        push(1'b1, 8'h5C);
        cyc(); bus.dma_req = 1'b0;
        cyc(); cyc(); cyc();
        bus.cart_ack = 1'b1; bus.cart_rdata = 8'h5C;
        cyc(); bus.cart_ack = 1'b0;
        @(negedge clk);
        check("tmoack_rvalid_N5", {31'd0, bus.dma_rvalid}, 32'd1);
        cyc();

        // Reset during CART_WAIT drops the read
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h4000;
        @(negedge clk);
        check("rst_mid_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        cyc(); bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mid_cart_req", {31'd0, bus.cart_req}, 32'd1);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0034;
        @(negedge clk);
        check("rst_mid_cart_req0", {31'd0, bus.cart_req}, 32'd0);
        check("rst_mid_use_cart", {31'd0, use_cart}, 32'd0);
        check("rst_mid_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
        check("rst_mid_new_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        push(1'b0, 8'h3E);
        cyc(); bus.cpu_req = 1'b0;
        cyc(); cyc(); cyc();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
